pueo_phase_monitor: RTL and testbench



---
 rtl/pueo_phase_mon_pkg.sv | 31 +++
 rtl/pueo_sat_counter.sv | 28 ++
 rtl/pueo_phase_monitor.sv | 138 +++++++++++++
 tb/tb_pueo_phase_monitor.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pueo_phase_mon_pkg.sv
// Shared types and the slot classifier for the phase-pulse monitor family.
package pueo_phase_mon_pkg;

    typedef enum logic [1:0] {
        UNLOCKED,
        ACQUIRE,
        LOCKED
    } phase_mon_state_t;

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_HIT,
        SLOT_MISS,
        SLOT_STRAY
    } slot_class_t;

    // slot_end is true when the flywheel sits on the last phase of the period,
    // i.e. the cycle in which the aligner's pulse is expected.
    function automatic slot_class_t classify_slot(input logic sync, input logic slot_end);
        slot_class_t cls;
        cls = SLOT_IDLE;
        if (sync && slot_end)
            cls = SLOT_HIT;
        else if (sync)
            cls = SLOT_STRAY;
        else if (slot_end)
            cls = SLOT_MISS;
        return cls;
    endfunction

endpackage

// File: rtl/pueo_sat_counter.sv
// Saturating event counter; a clear coinciding with an increment loads 1 so
// the event that arrived with the clear is not lost.
module pueo_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= '0;
        else if (clr)
            r_count <= inc ? WIDTH'(1) : '0;
        else if (inc && (r_count != '1))
            r_count <= r_count + WIDTH'(1);
    end

    assign count = r_count;

endmodule

// File: rtl/pueo_phase_monitor.sv
// Flywheel checker for the aligner's one-per-period phase pulse: acquires lock
// on a run of well-spaced pulses, then flags missing or stray pulses.
module pueo_phase_monitor
    import pueo_phase_mon_pkg::*;
#(
    parameter int PERIOD     = 3,
    parameter int LOCK_COUNT = 8,
    parameter int MISS_LIMIT = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      sync_i,
    input  logic                      err_clr_i,
    output logic                      locked_o,
    output logic [$clog2(PERIOD)-1:0] phase_o,
    output logic                      first_o,
    output logic                      err_o,
    output logic [CNT_WIDTH-1:0]      err_count_o
);

    localparam int PW = $clog2(PERIOD);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(MISS_LIMIT + 1);

    localparam logic [PW-1:0] P_LAST   = PW'(PERIOD - 1);
    localparam logic [GW-1:0] G_TARGET = GW'(LOCK_COUNT);
    localparam logic [MW-1:0] M_LIMIT  = MW'(MISS_LIMIT);

    phase_mon_state_t r_state, w_state_nxt;
    logic [PW-1:0]    r_phase, w_phase_nxt;
    logic [GW-1:0]    r_good, w_good_nxt, w_good_inc;
    logic [MW-1:0]    r_miss_run, w_miss_nxt, w_miss_inc;
    logic             r_err, w_err_nxt;
    slot_class_t      w_slot;

    assign w_slot     = classify_slot(sync_i, r_phase == P_LAST);
    assign w_good_inc = r_good + GW'(1);
    assign w_miss_inc = r_miss_run + MW'(1);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= UNLOCKED;
            r_phase    <= '0;
            r_good     <= '0;
            r_miss_run <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            r_good     <= w_good_nxt;
            r_miss_run <= w_miss_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case arms can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = (r_phase == P_LAST) ? '0 : r_phase + PW'(1);
        w_good_nxt  = r_good;
        w_miss_nxt  = r_miss_run;
        w_err_nxt   = 1'b0;

        unique case (r_state)
            UNLOCKED: begin
                if (sync_i) begin
                    w_phase_nxt = '0;
                    w_good_nxt  = GW'(1);
                    w_state_nxt = ACQUIRE;
                end
            end

            ACQUIRE: begin
                unique case (w_slot)
                    SLOT_HIT: begin
                        if (w_good_inc == G_TARGET) begin
                            w_state_nxt = LOCKED;
                            w_good_nxt  = '0;
                            w_miss_nxt  = '0;
                        end else begin
                            w_good_nxt = w_good_inc;
                        end
                    end
                    SLOT_STRAY: begin
                        w_phase_nxt = '0;
                        w_good_nxt  = GW'(1);
                    end
                    SLOT_MISS: begin
                        w_state_nxt = UNLOCKED;
                        w_good_nxt  = '0;
                    end
                    default: ;
                endcase
            end

            LOCKED: begin
                // Phase is never reseeded here: a stray pulse is reported, not followed.
                unique case (w_slot)
                    SLOT_HIT: w_miss_nxt = '0;
                    SLOT_MISS, SLOT_STRAY: begin
                        w_err_nxt = 1'b1;
                        if (w_miss_inc == M_LIMIT) begin
                            w_state_nxt = UNLOCKED;
                            w_miss_nxt  = '0;
                        end else begin
                            w_miss_nxt = w_miss_inc;
                        end
                    end
                    default: ;
                endcase
            end

            default: begin
                w_state_nxt = UNLOCKED;
                w_good_nxt  = '0;
                w_miss_nxt  = '0;
            end
        endcase
    end

    pueo_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_err_counter (
        .clk   (aclk),
        .rst_n (aresetn),
        .inc   (w_err_nxt),
        .clr   (err_clr_i),
        .count (err_count_o)
    );

    assign locked_o = (r_state == LOCKED);
    assign phase_o  = r_phase;
    assign first_o  = locked_o && (r_phase == '0);
    assign err_o    = r_err;

endmodule

// File: tb/tb_pueo_phase_monitor.sv
// Self-checking bench for pueo_phase_monitor: directed lock/unlock scenarios
// followed by randomized pulse trains, all compared against a cycle model.
module tb_pueo_phase_monitor;

    localparam int PERIOD     = 3;
    localparam int LOCK_COUNT = 8;
    localparam int MISS_LIMIT = 2;
    localparam int CNT_WIDTH  = 4;
    localparam int PW         = $clog2(PERIOD);
    localparam int CNT_MAX    = (1 << CNT_WIDTH) - 1;
    localparam int LOCK_EDGES = (LOCK_COUNT - 1) * PERIOD;

    logic                 aclk = 1'b0;
    logic                 aresetn = 1'b0;
    logic                 sync_i = 1'b0;
    logic                 err_clr_i = 1'b0;
    logic                 locked_o;
    logic [PW-1:0]        phase_o;
    logic                 first_o;
    logic                 err_o;
    logic [CNT_WIDTH-1:0] err_count_o;

    pueo_phase_monitor #(
        .PERIOD     (PERIOD),
        .LOCK_COUNT (LOCK_COUNT),
        .MISS_LIMIT (MISS_LIMIT),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .sync_i      (sync_i),
        .err_clr_i   (err_clr_i),
        .locked_o    (locked_o),
        .phase_o     (phase_o),
        .first_o     (first_o),
        .err_o       (err_o),
        .err_count_o (err_count_o)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_pass   = 0;
    int t        = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference model: mode 0 = hunting, 1 = counting good pulses, 2 = locked.
    int m_mode, m_ph, m_good, m_bad, m_err, m_cnt;

    task automatic model_reset();
        m_mode = 0; m_ph = 0; m_good = 0; m_bad = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input bit s, input bit clr);
        bit expected_slot;
        bit bad;
        int nph;
        expected_slot = (m_ph == PERIOD - 1);
        bad = 0;
        nph = (m_ph + 1) % PERIOD;
        if (m_mode == 0) begin
            if (s) begin nph = 0; m_good = 1; m_mode = 1; end
        end else if (m_mode == 1) begin
            if (s && expected_slot) begin
                m_good++;
                if (m_good == LOCK_COUNT) begin m_mode = 2; m_good = 0; m_bad = 0; end
            end else if (s) begin
                nph = 0; m_good = 1;
            end else if (expected_slot) begin
                m_mode = 0; m_good = 0;
            end
        end else begin
            if (s && expected_slot)
                m_bad = 0;
            else if (s || expected_slot) begin
                bad = 1;
                m_bad++;
                if (m_bad == MISS_LIMIT) begin m_mode = 0; m_bad = 0; end
            end
        end
        m_err = bad;
        if (clr)
            m_cnt = bad ? 1 : 0;
        else if (bad && m_cnt < CNT_MAX)
            m_cnt++;
        m_ph = nph;
    endtask

    task automatic compare_all();
        check("locked", locked_o, m_mode == 2);
        check("phase", phase_o, m_ph);
        check("first", first_o, (m_mode == 2) && (m_ph == 0));
        check("err", err_o, m_err);
        check("err_count", err_count_o, m_cnt);
    endtask

    // Drive one cycle's inputs, let the edge happen, then compare at the falling edge.
    task automatic step(input bit s, input bit clr);
        sync_i    = s;
        err_clr_i = clr;
        @(posedge aclk);
        model_edge(s, clr);
        @(negedge aclk);
        compare_all();
    endtask

    task automatic nominal(input int n);
        repeat (n) begin t++; step(t % PERIOD == 0, 1'b0); end
    endtask

    task automatic tick(input bit s);
        t++;
        step(s, 1'b0);
    endtask

    task automatic to_slot();
        while ((t + 1) % PERIOD != 0) begin t++; step(t % PERIOD == 0, 1'b0); end
    endtask

    task automatic wait_lock(output int k);
        k = 0;
        while (!locked_o && k < 4 * LOCK_EDGES) begin t++; k++; step(t % PERIOD == 0, 1'b0); end
    endtask

    task automatic async_reset(input string tag);
        #2 aresetn = 1'b0;
        sync_i = 1'b0; err_clr_i = 1'b0;
        #1;
        check({tag, "_locked"}, locked_o, 0);
        check({tag, "_phase"}, phase_o, 0);
        check({tag, "_first"}, first_o, 0);
        check({tag, "_err"}, err_o, 0);
        check({tag, "_count"}, err_count_o, 0);
        model_reset();
        @(posedge aclk);
        @(negedge aclk);
        #2 aresetn = 1'b1;
    endtask

    task automatic random_run(input int cycles, input int fault_pct);
        int src;
        logic s, clr;
        src = 0;
        for (int i = 0; i < cycles; i++) begin
            if ($urandom_range(999) < 3) begin
                async_reset("rnd_rst");
                continue;
            end
            src = (src + 1) % PERIOD;
            s = (src == 0);
            if ($urandom_range(99) < fault_pct) s = ~s;
            if ($urandom_range(199) == 0) src = $urandom_range(PERIOD - 1);
            clr = ($urandom_range(49) == 0);
            step(s, clr);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        model_reset();
        repeat (2) @(negedge aclk);
        check("reset_locked", locked_o, 0);
        check("reset_count", err_count_o, 0);
        #2 aresetn = 1'b1;

        // Clean lock from a fresh reset.
        t = 0;
        step(1'b1, 1'b0);
        wait_lock(k);
        check("lock_latency", k, LOCK_EDGES);
        check("lock_first", first_o, 1);
        check("lock_phase0", phase_o, 0);
        for (int i = 1; i <= PERIOD; i++) begin
            nominal(1);
            check("phase_seq", phase_o, i % PERIOD);
        end

        // Isolated drops while locked: reported, lock held, hit clears the run.
        to_slot(); tick(1'b0);
        check("drop1_err", err_o, 1);
        check("drop1_count", err_count_o, 1);
        check("drop1_locked", locked_o, 1);
        to_slot(); tick(1'b1);
        check("hit_err", err_o, 0);
        to_slot(); tick(1'b0);
        to_slot(); tick(1'b1);
        to_slot(); tick(1'b0);
        check("drop3_locked", locked_o, 1);
        check("drop3_count", err_count_o, 3);
        to_slot(); tick(1'b0);
        check("unlock_locked", locked_o, 0);
        check("unlock_err", err_o, 1);
        check("unlock_count", err_count_o, 4);

        // Stray pulse during acquisition reseeds the count.
        t = 0;
        step(1'b1, 1'b0);
        nominal(4 * PERIOD);
        nominal(PERIOD - 2);
        tick(1'b1);
        check("stray_err", err_o, 0);
        t = 0;
        wait_lock(k);
        check("stray_relock", k, LOCK_EDGES);
        check("stray_count", err_count_o, 4);

        // Saturation, then clear with and without a coincident error.
        repeat (20) begin
            to_slot(); tick(1'b0);
            to_slot(); tick(1'b1);
        end
        check("sat_count", err_count_o, CNT_MAX);
        check("sat_locked", locked_o, 1);
        to_slot(); t++; step(1'b0, 1'b1);
        check("clr_inc_count", err_count_o, 1);
        to_slot(); tick(1'b1);
        t++; step(t % PERIOD == 0, 1'b1);
        check("clr_count", err_count_o, 0);

        // Asynchronous reset while locked, then a full relock.
        async_reset("lock_rst");
        t = 0;
        step(1'b1, 1'b0);
        wait_lock(k);
        check("reset_relock", k, LOCK_EDGES);

        random_run(1000, 0);
        random_run(1500, 3);
        random_run(1000, 15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
